// File: rtl/mem_ctrl.sv
// Byte-wide RAM controller/arbiter shared by icache fetches and LSB loads/stores.
// Each request is serialised into byte beats; reads are assembled little-endian.
module mem_ctrl #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] IO_BASE    = 32'h00030000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full,
  input  logic                  IC2MC_en,
  input  logic [ADDR_WIDTH-1:0] IC2MC_addr,
  output logic                  MC2IC_en,
  output logic [31:0]           MC2IC_data,
  input  logic                  LSB2MC_en,
  input  logic                  LSB2MC_wr,
  input  logic [ADDR_WIDTH-1:0] LSB2MC_addr,
  input  logic [1:0]            LSB2MC_len,
  input  logic [31:0]           LSB2MC_data,
  output logic                  MC2LSB_en,
  output logic [31:0]           MC2LSB_data,
  input  logic                  ROB2MC_flush
);

  typedef enum logic [1:0] {IDLE = 2'd0, IC_RD = 2'd1, LSB_RD = 2'd2, LSB_WR = 2'd3} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            nbeats;
    logic [31:0]           data;
  } req_t;

  state_t                state, state_nxt;
  req_t                  req_q;
  logic [2:0]            cnt;
  logic [23:0]           rbuf;
  logic                  last_grant;   // 0 = IC, 1 = LSB
  logic                  grant_ic, grant_lsb;
  logic                  lsb_io_st, lsb_ok;
  logic [2:0]            lsb_nbeats;
  logic                  rd_last, wr_last;
  logic [31:0]           rd_word;
  logic [ADDR_WIDTH-1:0] beat_addr;

  assign lsb_nbeats = (LSB2MC_len == 2'b00) ? 3'd1 :
                      (LSB2MC_len == 2'b01) ? 3'd2 : 3'd4;
  assign lsb_io_st  = LSB2MC_wr && (LSB2MC_addr[17:16] == IO_BASE[17:16]);
  assign lsb_ok     = LSB2MC_en && !(lsb_io_st && io_buffer_full);
  assign rd_last    = (cnt == req_q.nbeats);
  assign wr_last    = (cnt == req_q.nbeats - 3'd1);
  assign beat_addr  = req_q.addr + {{(ADDR_WIDTH-3){1'b0}}, cnt};

  // ---------------- state register ----------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)      state <= IDLE;
    else if (rdy_in)  state <= state_nxt;
  end

  // ---------------- next state / arbitration ----------------
  always_comb begin
    state_nxt = state;
    grant_ic  = 1'b0;
    grant_lsb = 1'b0;
    case (state)
      IDLE: begin
        if (!ROB2MC_flush) begin
          if (IC2MC_en && lsb_ok) begin
            grant_lsb = (last_grant == 1'b0);
            grant_ic  = (last_grant == 1'b1);
          end else begin
            grant_ic  = IC2MC_en;
            grant_lsb = lsb_ok;
          end
        end
        if (grant_ic)       state_nxt = IC_RD;
        else if (grant_lsb) state_nxt = LSB2MC_wr ? LSB_WR : LSB_RD;
      end
      IC_RD, LSB_RD: begin
        if (ROB2MC_flush || rd_last) state_nxt = IDLE;
      end
      LSB_WR: begin
        // committed stores always run to completion, flush or not
        if (wr_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // final byte is still on mem_din at the completing edge, so bypass it in
  always_comb begin
    case (req_q.nbeats)
      3'd1:    rd_word = {24'h0, mem_din};
      3'd2:    rd_word = {16'h0, mem_din, rbuf[7:0]};
      default: rd_word = {mem_din, rbuf};
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      req_q       <= '0;
      cnt         <= 3'd0;
      rbuf        <= 24'h0;
      last_grant  <= 1'b0;
      MC2IC_en    <= 1'b0;
      MC2IC_data  <= 32'h0;
      MC2LSB_en   <= 1'b0;
      MC2LSB_data <= 32'h0;
    end else if (rdy_in) begin
      MC2IC_en  <= 1'b0;
      MC2LSB_en <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ic) begin
            req_q.addr   <= IC2MC_addr;
            req_q.nbeats <= 3'd4;
            cnt          <= 3'd0;
            rbuf         <= 24'h0;
            last_grant   <= 1'b0;
          end else if (grant_lsb) begin
            req_q.addr   <= LSB2MC_addr;
            req_q.nbeats <= lsb_nbeats;
            req_q.data   <= LSB2MC_data;
            cnt          <= 3'd0;
            rbuf         <= 24'h0;
            last_grant   <= 1'b1;
          end
        end
        IC_RD, LSB_RD: begin
          if (ROB2MC_flush) begin
            cnt <= 3'd0;
          end else if (rd_last) begin
            cnt <= 3'd0;
            if (state == IC_RD) begin
              MC2IC_en   <= 1'b1;
              MC2IC_data <= rd_word;
            end else begin
              MC2LSB_en   <= 1'b1;
              MC2LSB_data <= rd_word;
            end
          end else begin
            cnt <= cnt + 3'd1;
            // byte addressed in beat cnt-1 is on mem_din now
            case (cnt)
              3'd1:    rbuf[7:0]   <= mem_din;
              3'd2:    rbuf[15:8]  <= mem_din;
              3'd3:    rbuf[23:16] <= mem_din;
              default: ;
            endcase
          end
        end
        LSB_WR: begin
          if (wr_last) begin
            cnt       <= 3'd0;
            MC2LSB_en <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: cnt <= 3'd0;
      endcase
    end
  end

  // ---------------- bus outputs ----------------
  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = 8'h0;
    case (state)
      IC_RD, LSB_RD: begin
        if (cnt < req_q.nbeats) mem_a = beat_addr;
      end
      LSB_WR: begin
        mem_a  = beat_addr;
        mem_wr = 1'b1;
        case (cnt[1:0])
          2'd0:    mem_dout = req_q.data[7:0];
          2'd1:    mem_dout = req_q.data[15:8];
          2'd2:    mem_dout = req_q.data[23:16];
          default: mem_dout = req_q.data[31:24];
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-serial RAM model, arbitration, flush, IO stall, rdy freeze, reset.
module tb_mem_ctrl;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [7:0]  mem_din = 8'h0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        IC2MC_en;
  logic [31:0] IC2MC_addr;
  logic        MC2IC_en;
  logic [31:0] MC2IC_data;
  logic        LSB2MC_en, LSB2MC_wr;
  logic [31:0] LSB2MC_addr;
  logic [1:0]  LSB2MC_len;
  logic [31:0] LSB2MC_data;
  logic        MC2LSB_en;
  logic [31:0] MC2LSB_data;
  logic        ROB2MC_flush;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .IC2MC_en(IC2MC_en), .IC2MC_addr(IC2MC_addr),
    .MC2IC_en(MC2IC_en), .MC2IC_data(MC2IC_data),
    .LSB2MC_en(LSB2MC_en), .LSB2MC_wr(LSB2MC_wr), .LSB2MC_addr(LSB2MC_addr),
    .LSB2MC_len(LSB2MC_len), .LSB2MC_data(LSB2MC_data),
    .MC2LSB_en(MC2LSB_en), .MC2LSB_data(MC2LSB_data),
    .ROB2MC_flush(ROB2MC_flush)
  );

  // RAM model: preload image plus written-byte overlay, one-cycle read latency
  logic [7:0] init_ram [0:262143];
  logic [7:0] wram     [0:262143];
  logic       wvalid   [0:262143];

  function automatic logic [7:0] rd(input logic [17:0] a);
    return (wvalid[a] === 1'b1) ? wram[a] : init_ram[a];
  endfunction

  always @(posedge clk_in) begin
    if (rdy_in) begin
      mem_din <= rd(mem_a[17:0]);
      if (mem_wr) begin
        wram[mem_a[17:0]]   <= mem_dout;
        wvalid[mem_a[17:0]] <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ic(input int maxc);
    int n = 0;
    while (MC2IC_en !== 1'b1 && n < maxc) begin
      @(negedge clk_in);
      n++;
    end
    chk("ic_pulse_wait", {31'h0, MC2IC_en}, 32'h1);
  endtask

  task automatic wait_lsb(input int maxc);
    int n = 0;
    while (MC2LSB_en !== 1'b1 && n < maxc) begin
      @(negedge clk_in);
      n++;
    end
    chk("lsb_pulse_wait", {31'h0, MC2LSB_en}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    init_ram[18'h00000] = 8'h00;
    init_ram[18'h00100] = 8'h13; init_ram[18'h00101] = 8'h00;
    init_ram[18'h00102] = 8'h00; init_ram[18'h00103] = 8'h00;
    init_ram[18'h00104] = 8'h01; init_ram[18'h00105] = 8'h02;
    init_ram[18'h00106] = 8'h03; init_ram[18'h00107] = 8'h04;
    init_ram[18'h00202] = 8'h5A;
    init_ram[18'h00300] = 8'h11; init_ram[18'h00301] = 8'h22;
    init_ram[18'h00302] = 8'h33; init_ram[18'h00303] = 8'h44;
    init_ram[18'h00400] = 8'h8F;

    rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; ROB2MC_flush = 1'b0;
    IC2MC_en = 1'b0; IC2MC_addr = 32'h0;
    LSB2MC_en = 1'b0; LSB2MC_wr = 1'b0; LSB2MC_addr = 32'h0; LSB2MC_len = 2'b00; LSB2MC_data = 32'h0;

    // reset state
    #2;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("rst_ic_en", {31'h0, MC2IC_en}, 32'h0);
    chk("rst_lsb_en", {31'h0, MC2LSB_en}, 32'h0);
    chk("rst_ic_data", MC2IC_data, 32'h0);
    chk("rst_lsb_data", MC2LSB_data, 32'h0);
    @(negedge clk_in); rst_in = 1'b1;

    // IC fetch 0x100
    @(negedge clk_in); IC2MC_en = 1'b1; IC2MC_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk("ic_beat_addr", mem_a, 32'h100 + 32'(k));
      chk("ic_beat_wr", {31'h0, mem_wr}, 32'h0);
    end
    @(negedge clk_in);
    chk("ic_c4_noen", {31'h0, MC2IC_en}, 32'h0);
    chk("ic_c4_addr", mem_a, 32'h0);
    @(negedge clk_in);
    chk("ic_c5_en", {31'h0, MC2IC_en}, 32'h1);
    chk("ic_c5_data", MC2IC_data, 32'h00000013);
    IC2MC_en = 1'b0;
    @(negedge clk_in);
    chk("ic_c6_en", {31'h0, MC2IC_en}, 32'h0);
    chk("ic_c6_hold", MC2IC_data, 32'h00000013);

    // LSB half store to 0x200
    LSB2MC_en = 1'b1; LSB2MC_wr = 1'b1; LSB2MC_addr = 32'h200; LSB2MC_len = 2'b01; LSB2MC_data = 32'hABCD1234;
    @(negedge clk_in);
    chk("st_c0_wr", {31'h0, mem_wr}, 32'h1);
    chk("st_c0_addr", mem_a, 32'h200);
    chk("st_c0_dout", {24'h0, mem_dout}, 32'h34);
    @(negedge clk_in);
    chk("st_c1_addr", mem_a, 32'h201);
    chk("st_c1_dout", {24'h0, mem_dout}, 32'h12);
    @(negedge clk_in);
    chk("st_c2_en", {31'h0, MC2LSB_en}, 32'h1);
    chk("st_c2_wr", {31'h0, mem_wr}, 32'h0);
    chk("st_c2_addr", mem_a, 32'h0);
    LSB2MC_en = 1'b0; LSB2MC_wr = 1'b0;
    @(negedge clk_in);
    chk("st_ram", {8'h0, rd(18'h202), rd(18'h201), rd(18'h200)}, 32'h005A1234);

    // arbitration from reset: LSB first, then IC, then LSB again
    rst_in = 1'b0;
    @(negedge clk_in); rst_in = 1'b1;
    IC2MC_en = 1'b1; IC2MC_addr = 32'h300;
    LSB2MC_en = 1'b1; LSB2MC_wr = 1'b0; LSB2MC_addr = 32'h400; LSB2MC_len = 2'b00;
    @(negedge clk_in);
    chk("arb_lsb_first", mem_a, 32'h400);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("arb_lsb_pulse", {31'h0, MC2LSB_en}, 32'h1);
    chk("ld_byte_zext", MC2LSB_data, 32'h0000008F);
    LSB2MC_en = 1'b0;
    @(negedge clk_in);
    chk("arb_ic_next", mem_a, 32'h300);
    wait_ic(8);
    chk("ic_word", MC2IC_data, 32'h44332211);
    LSB2MC_en = 1'b1;
    @(negedge clk_in);
    chk("arb_lsb_again", mem_a, 32'h400);
    wait_lsb(4);
    LSB2MC_en = 1'b0;
    wait_ic(8);
    IC2MC_en = 1'b0;
    @(negedge clk_in);

    // flush during IC fetch
    IC2MC_en = 1'b1; IC2MC_addr = 32'h104;
    @(negedge clk_in);
    @(negedge clk_in);
    @(negedge clk_in); ROB2MC_flush = 1'b1; IC2MC_en = 1'b0;
    @(negedge clk_in); ROB2MC_flush = 1'b0;
    chk("flush_addr0", mem_a, 32'h0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      seen = seen | MC2IC_en;
    end
    chk("flush_no_pulse", {31'h0, seen}, 32'h0);
    chk("flush_data_hold", MC2IC_data, 32'h44332211);

    // flush during LSB word store is ignored
    LSB2MC_en = 1'b1; LSB2MC_wr = 1'b1; LSB2MC_addr = 32'h500; LSB2MC_len = 2'b10; LSB2MC_data = 32'hDEADBEEF;
    @(negedge clk_in);
    chk("wst_c0", {mem_a[23:0], mem_dout}, 32'h000500EF);
    @(negedge clk_in); ROB2MC_flush = 1'b1;
    @(negedge clk_in); ROB2MC_flush = 1'b0;
    chk("wst_c2", {mem_a[23:0], mem_dout}, 32'h000502AD);
    chk("wst_c2_wr", {31'h0, mem_wr}, 32'h1);
    wait_lsb(4);
    LSB2MC_en = 1'b0; LSB2MC_wr = 1'b0;
    @(negedge clk_in);
    chk("wst_ram", {rd(18'h503), rd(18'h502), rd(18'h501), rd(18'h500)}, 32'hDEADBEEF);

    // IC fetch so last_grant = IC before the IO test
    IC2MC_en = 1'b1; IC2MC_addr = 32'h104;
    @(negedge clk_in);
    wait_ic(8);
    chk("ic_word2", MC2IC_data, 32'h04030201);
    IC2MC_en = 1'b0;
    @(negedge clk_in);

    // IO store stalled while buffer full; IC served instead
    io_buffer_full = 1'b1;
    LSB2MC_en = 1'b1; LSB2MC_wr = 1'b1; LSB2MC_addr = 32'h30000; LSB2MC_len = 2'b00; LSB2MC_data = 32'h00000077;
    IC2MC_en = 1'b1; IC2MC_addr = 32'h100;
    @(negedge clk_in);
    chk("io_ic_first", mem_a, 32'h100);
    wait_ic(8);
    IC2MC_en = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      seen = seen | mem_wr;
    end
    chk("io_stalled", {31'h0, seen}, 32'h0);
    io_buffer_full = 1'b0;
    @(negedge clk_in);
    chk("io_st_go", {mem_a[23:0], mem_dout}, 32'h03000077);
    chk("io_st_wr", {31'h0, mem_wr}, 32'h1);
    wait_lsb(4);
    LSB2MC_en = 1'b0; LSB2MC_wr = 1'b0;
    @(negedge clk_in);

    // IO load not affected by full buffer
    io_buffer_full = 1'b1;
    LSB2MC_en = 1'b1; LSB2MC_addr = 32'h30000; LSB2MC_len = 2'b00;
    @(negedge clk_in);
    chk("io_ld_grant", mem_a, 32'h30000);
    wait_lsb(4);
    chk("io_ld_data", MC2LSB_data, 32'h00000077);
    LSB2MC_en = 1'b0; io_buffer_full = 1'b0;
    @(negedge clk_in);

    // rdy_in low freezes the fetch
    IC2MC_en = 1'b1; IC2MC_addr = 32'h100;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("rdy_pre", mem_a, 32'h101);
    rdy_in = 1'b0;
    @(negedge clk_in);
    chk("rdy_hold1", mem_a, 32'h101);
    @(negedge clk_in);
    chk("rdy_hold2", mem_a, 32'h101);
    rdy_in = 1'b1;
    wait_ic(8);
    chk("rdy_data", MC2IC_data, 32'h00000013);
    IC2MC_en = 1'b0;
    @(negedge clk_in);

    // async reset mid-read, then a clean fetch
    IC2MC_en = 1'b1; IC2MC_addr = 32'h104;
    @(negedge clk_in);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk("mrst_addr", mem_a, 32'h0);
    chk("mrst_ic_data", MC2IC_data, 32'h0);
    chk("mrst_lsb_data", MC2LSB_data, 32'h0);
    @(negedge clk_in); rst_in = 1'b1;
    @(negedge clk_in);
    chk("mrst_refetch", mem_a, 32'h104);
    wait_ic(8);
    chk("mrst_data", MC2IC_data, 32'h04030201);
    IC2MC_en = 1'b0;
    @(negedge clk_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Single-port RAM controller and arbiter sharing the byte-wide memory bus between the instruction cache (word fetches) and the load/store buffer (byte/half/word loads and stores). It serialises each request into byte beats, assembles or scatters 32-bit data, and applies fair arbitration. It also aborts speculative reads on a ROB flush and stalls stores to the IO region while the IO buffer is full.

Parameters:
ADDR_WIDTH, 32, width of all address ports and mem_a
IO_BASE, 32'h00030000, base of IO region; IO address = addr[17:16]==2'b11

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-low reset
rdy_in  input  1  global ready; low freezes all state
mem_din  input  8  RAM read byte
mem_dout  output  8  RAM write byte
mem_a  output  ADDR_WIDTH  RAM byte address
mem_wr  output  1  1 = write, 0 = read
io_buffer_full  input  1  IO write buffer full
IC2MC_en  input  1  icache fetch request, held until MC2IC_en
IC2MC_addr  input  ADDR_WIDTH  fetch address
MC2IC_en  output  1  one-cycle fetch-done pulse
MC2IC_data  output  32  fetched word, little-endian
LSB2MC_en  input  1  LSB request, held until MC2LSB_en
LSB2MC_wr  input  1  1 = store, 0 = load
LSB2MC_addr  input  ADDR_WIDTH  access address
LSB2MC_len  input  2  00 byte, 01 half, 10/11 word
LSB2MC_data  input  32  store data, low bytes used
MC2LSB_en  output  1  one-cycle done pulse, load or store
MC2LSB_data  output  32  load data, zero-extended
ROB2MC_flush  input  1  mispredict flush

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE, byte counter 0, last_grant=IC. mem_a, mem_dout, mem_wr, MC2IC_en, MC2LSB_en, MC2IC_data and MC2LSB_data are all 0.
- rdy_in low: no register changes. Inputs, including the flush, are ignored that edge.
- States: IDLE, IC_RD, LSB_RD, LSB_WR.
- Arbitration (IDLE only, no flush):
  - If exactly one requester has en high, it is granted.
  - If both have en high, grant goes to the requester that is not last_grant.
  - last_grant updates on each grant.
- Acceptance edge is E0; cycle k follows edge Ek. N = 4 for IC and for len 1x, 2 for len 01, 1 for len 00.
- Read sequence:
  - mem_a = addr+k and mem_wr = 0 in cycles 0..N-1.
  - The byte addressed in cycle c appears on mem_din in cycle c+1 and is stored into data[8k+7:8k] at edge E(k+2).
  - The done pulse and data are set at edge E(N+1), so the pulse is high in cycle N+1.
  - State returns to IDLE at E(N+1). The next grant is possible at E(N+2).
- Write sequence:
  - mem_a = addr+k, mem_wr = 1 and mem_dout = data[8k+7:8k] in cycles 0..N-1.
  - MC2LSB_en is high in cycle N, with mem_wr = 0 and mem_a = 0.
  - State returns to IDLE at EN.
- Outside active beats: mem_a = 0, mem_wr = 0, mem_dout = 0.
- Address increment is modulo 2^ADDR_WIDTH and wraps with no error.
- Unused high bytes of MC2LSB_data are 0; sign extension is the LSB's job.
- Output data regs hold their value until the next done pulse of the same requester.
- IO stall: an LSB store to an IO address is not granted while io_buffer_full = 1 at the arbitration edge. IC may be granted in its place. IO loads are unaffected.
- Flush (ROB2MC_flush high at an edge):
  - In IC_RD or LSB_RD: abort, go to IDLE, drive mem_a/mem_wr to 0, no done pulse.
  - In LSB_WR: the flush is ignored and the store completes, since stores are committed.
  - In IDLE: no grant at that edge.
- Requesters must not drop en before their done pulse, except via flush.
- en seen high again in the pulse cycle is a new request.

Test Plan:
- IC fetch 0x100, RAM [0x100..0x103] = 13,00,00,00 -> mem_a 0x100..0x103 in cycles 0–3, MC2IC_en in cycle 5, MC2IC_data = 32'h00000013.
- LSB store len 01 to 0x200, data 0xABCD1234 -> cycles 0–1: mem_wr = 1, (0x200, 0x34), (0x201, 0x12); MC2LSB_en in cycle 2; RAM unchanged at 0x202.
- IC and LSB load both pending from reset -> LSB granted first (last_grant = IC), IC granted at the edge after the LSB pulse; then reissue both -> LSB granted again.
- Flush asserted in cycle 2 of an IC fetch -> mem_a = 0 next cycle, no MC2IC_en pulse, IDLE. Repeat during an LSB word store -> all 4 bytes written and MC2LSB_en pulses.
- LSB store to 0x30000 with io_buffer_full = 1 for 3 cycles while IC requests -> IC served first, store granted only after full drops.
- rst_in pulled low mid-read (cycle 2) -> all outputs 0 immediately; after release a new fetch completes normally.
